// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and helpers for serial_frame_writer
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_FETCH,
        ST_DATA,
        ST_ACK,
        ST_DONE
    } state_t;

    // A zero-length burst still carries one word; oversize requests clip to the max.
    function automatic int sat_burst(input int len, input int max_burst);
        if (len == 0)
            return 1;
        else if (len > max_burst)
            return max_burst;
        else
            return len;
    endfunction

    function automatic int bit_cnt_w(input int a_w, input int d_w);
        return $clog2(((a_w > d_w) ? a_w : d_w) + 1);
    endfunction

endpackage

// File: rtl/serial_shift_out.sv
// rtl/serial_shift_out.sv - parallel-load shift register presenting one serial bit
module serial_shift_out #(
    parameter int W         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         bit_out
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst)
            sr <= '0;
        else if (load)
            sr <= din;
        else if (shift)
            sr <= (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
    end

    assign bit_out = (MSB_FIRST != 0) ? sr[W-1] : sr[0];

endmodule

// File: rtl/serial_frame_writer.sv
// rtl/serial_frame_writer.sv - address + data-burst serial transmitter; SERIAL_WRITER_ACK_EN adds per-word ack slots
module serial_frame_writer
    import serial_frame_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_valid,
    output logic                             start_ready,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len,
    input  logic                             data_valid,
    output logic                             data_ready,
    input  logic [DATA_W-1:0]                data,
    output logic                             sda_out,
    output logic                             sda_oe,
    input  logic                             sda_in,
    output logic                             done,
    output logic                             nack
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = bit_cnt_w(ADDR_W, DATA_W);
    localparam int BL_W  = $clog2(MAX_BURST + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [BL_W-1:0]  words_left;
    logic             start_hs, data_hs, last_bit, last_word, post_word, shifting;
    logic [MAX_W-1:0] addr_pad, data_pad;
    logic             sda_oe_d, done_d;

    assign start_ready = rst && (state == ST_IDLE);
    assign data_ready  = rst && (state == ST_FETCH);
    assign start_hs    = start_valid && start_ready;
    assign data_hs     = data_valid && data_ready;
    assign last_bit    = (bit_cnt == '0);
    assign last_word   = (words_left == BL_W'(1));
    assign shifting    = (state == ST_ADDR) || (state == ST_DATA);

`ifdef SERIAL_WRITER_ACK_EN
    logic ack_addr;
    logic nack_d;
    assign post_word = (state == ST_ACK) && !sda_in && !ack_addr;
`else
    logic unused_sda_in;
    assign unused_sda_in = sda_in;
    assign post_word     = (state == ST_DATA) && last_bit;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start_hs) state_nx = ST_ADDR;
`ifdef SERIAL_WRITER_ACK_EN
            ST_ADDR:  if (last_bit) state_nx = ST_ACK;
            ST_DATA:  if (last_bit) state_nx = ST_ACK;
            ST_ACK: begin
                if (sda_in)
                    state_nx = ST_DONE;
                else if (ack_addr)
                    state_nx = ST_FETCH;
                else
                    state_nx = last_word ? ST_DONE : ST_FETCH;
            end
`else
            ST_ADDR:  if (last_bit) state_nx = ST_FETCH;
            ST_DATA:  if (post_word) state_nx = last_word ? ST_DONE : ST_FETCH;
`endif
            ST_FETCH: if (data_valid) state_nx = ST_DATA;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt    <= '0;
            words_left <= '0;
        end else begin
            if (start_hs) begin
                bit_cnt    <= CNT_W'(ADDR_W - 1);
                words_left <= BL_W'(sat_burst(int'(burst_len), MAX_BURST));
            end else if (data_hs) begin
                bit_cnt <= CNT_W'(DATA_W - 1);
            end else if (shifting && !last_bit) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (post_word)
                words_left <= words_left - 1'b1;
        end
    end

`ifdef SERIAL_WRITER_ACK_EN
    // Remembers whether the pending ack slot follows the address or a data word.
    always_ff @(posedge clk) begin
        if (!rst)
            ack_addr <= 1'b0;
        else if (state == ST_ADDR)
            ack_addr <= 1'b1;
        else if (state == ST_DATA)
            ack_addr <= 1'b0;
    end
`endif

    // Narrow words are padded so their first bit lands where the shifter emits from.
    assign addr_pad = (MSB_FIRST != 0) ? (MAX_W'(addr) << (MAX_W - ADDR_W)) : MAX_W'(addr);
    assign data_pad = (MSB_FIRST != 0) ? (MAX_W'(data) << (MAX_W - DATA_W)) : MAX_W'(data);

    serial_shift_out #(
        .W         (MAX_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (start_hs || data_hs),
        .shift   (shifting),
        .din     (start_hs ? addr_pad : data_pad),
        .bit_out (sda_out)
    );

    always_comb begin
        sda_oe_d = (state_nx == ST_ADDR) || (state_nx == ST_DATA);
        done_d   = (state_nx == ST_DONE);
`ifdef SERIAL_WRITER_ACK_EN
        nack_d   = (state == ST_ACK) && sda_in;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sda_oe <= 1'b0;
            done   <= 1'b0;
        end else begin
            sda_oe <= sda_oe_d;
            done   <= done_d;
        end
    end

`ifdef SERIAL_WRITER_ACK_EN
    always_ff @(posedge clk) begin
        if (!rst)
            nack <= 1'b0;
        else
            nack <= nack_d;
    end
`else
    assign nack = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_writer.sv
// tb/tb_serial_frame_writer.sv - directed self-checking bench for serial_frame_writer (MSB- and LSB-first instances)
module tb_serial_frame_writer;

`ifdef SERIAL_WRITER_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_valid = 1'b0;
    logic [7:0] addr = '0;
    logic [2:0] burst_len = '0;
    logic       data_valid = 1'b0;
    logic [7:0] data = '0;
    logic       sda_in = 1'b0;

    logic m_start_ready, m_data_ready, m_sda_out, m_sda_oe, m_done, m_nack;
    logic l_start_ready, l_data_ready, l_sda_out, l_sda_oe, l_done, l_nack;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_writer #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(m_start_ready),
        .addr(addr), .burst_len(burst_len), .data_valid(data_valid), .data_ready(m_data_ready),
        .data(data), .sda_out(m_sda_out), .sda_oe(m_sda_oe), .sda_in(sda_in),
        .done(m_done), .nack(m_nack)
    );

    serial_frame_writer #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(l_start_ready),
        .addr(addr), .burst_len(burst_len), .data_valid(data_valid), .data_ready(l_data_ready),
        .data(data), .sda_out(l_sda_out), .sda_oe(l_sda_oe), .sda_in(sda_in),
        .done(l_done), .nack(l_nack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    bit mbits[$];
    bit lbits[$];
    int lat, ndone, nready, stall_oe, nack_seen;

    function automatic logic [31:0] pack_bits(input bit q[$], input int off, input int w, input bit msb_first);
        logic [31:0] v = '0;
        bit b;
        for (int j = 0; j < w; j++) begin
            b = (off + j < q.size()) ? q[off + j] : 1'b0;
            if (msb_first) v = {v[30:0], b};
            else           v[j] = b;
        end
        return v;
    endfunction

    task automatic run_frame(input logic [7:0] a, input logic [2:0] bl, input logic [31:0] ws,
                             input int stall_idx, input int stall_n, input int rst_at, input logic sdain);
        int t, idx, left, guard, after;
        mbits.delete(); lbits.delete();
        lat = -1; ndone = 0; nready = 0; stall_oe = 0; nack_seen = 0;
        idx = 0; left = stall_n; guard = 0; after = 0;
        @(negedge clk);
        addr = a; burst_len = bl; start_valid = 1'b1; sda_in = sdain;
        while (!m_start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        t = cyc;
        data_valid = 1'b1;
        data = ws[7:0];
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            start_valid = 1'b0;
            if (m_sda_oe) mbits.push_back(m_sda_out);
            if (l_sda_oe) lbits.push_back(l_sda_out);
            if (m_done) begin
                ndone++;
                lat = cyc - t;
                nack_seen = m_nack;
            end
            if (m_data_ready) nready++;
            if (m_data_ready && idx == stall_idx && left > 0) begin
                data_valid = 1'b0;
                left--;
                if (m_sda_oe) stall_oe++;
            end else begin
                data_valid = (idx < 4);
                data = (idx < 4) ? ws[8*idx +: 8] : 8'h00;
            end
            if (m_data_ready && data_valid) idx++;
            if (ndone > 0) after++;
            if (rst_at > 0 && cyc == t + rst_at) begin
                rst = 1'b0;
                break;
            end
            if (after >= 3) break;
        end
        data_valid = 1'b0;
        sda_in = 1'b0;
        if (rst_at > 0) begin
            @(negedge clk);
            check_eq("rstmid_oe", m_sda_oe, 0);
            check_eq("rstmid_done", m_done, 0);
            check_eq("rstmid_start_ready", m_start_ready, 0);
            check_eq("rstmid_data_ready", m_data_ready, 0);
            rst = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (m_done) ndone++;
            end
            check_eq("rstmid_no_done", ndone, 0);
            check_eq("rstmid_idle_ready", m_start_ready, 1);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] a, input int nw,
                               input logic [31:0] ws, input int exp_lat);
        check_eq({tag, "_nbits"}, mbits.size(), 8 * (1 + nw));
        check_eq({tag, "_addr"}, pack_bits(mbits, 0, 8, 1'b1), {24'h0, a});
        for (int j = 0; j < nw; j++)
            check_eq($sformatf("%s_word%0d", tag, j), pack_bits(mbits, 8 * (j + 1), 8, 1'b1), {24'h0, ws[8*j +: 8]});
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_done_count"}, ndone, 1);
        check_eq({tag, "_nack"}, nack_seen, 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_sda_out", m_sda_out, 0);
        check_eq("rst_sda_oe", m_sda_oe, 0);
        check_eq("rst_done", m_done, 0);
        check_eq("rst_nack", m_nack, 0);
        check_eq("rst_data_ready", m_data_ready, 0);
        check_eq("rst_start_ready", m_start_ready, 0);
        rst = 1'b1;
        @(negedge clk);

        // addr A5, data 3C: bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; done at T+18
        run_frame(8'hA5, 3'd1, 32'h0000_003C, -1, 0, 0, 1'b0);
        check_frame("basic", 8'hA5, 1, 32'h0000_003C, 18 + 2 * ACK);

        // 3 words, 3 stall cycles before word 1: 8 + 27 + 1 + 3 = 39
        run_frame(8'h5A, 3'd3, 32'h0003_0201, 1, 3, 0, 1'b0);
        check_frame("stall", 8'h5A, 3, 32'h0003_0201, 39 + 4 * ACK);
        check_eq("stall_oe_low", stall_oe, 0);
        check_eq("stall_ready_cycles", nready, 6);

        run_frame(8'h01, 3'd1, 32'h0000_0080, -1, 0, 0, 1'b0);
        check_frame("order", 8'h01, 1, 32'h0000_0080, 18 + 2 * ACK);
        check_eq("lsb_first_bit", (lbits.size() > 0) ? lbits[0] : 1'b0, 1);
        check_eq("lsb_next7", pack_bits(lbits, 1, 7, 1'b1), 0);
        check_eq("lsb_data", pack_bits(lbits, 8, 8, 1'b0), 32'h80);

        run_frame(8'h3C, 3'd0, 32'h4433_22F0, -1, 0, 0, 1'b0);
        check_frame("blen0", 8'h3C, 1, 32'h4433_22F0, 18 + 2 * ACK);

        // 7 saturates to 4 words: 8 + 36 + 1 = 45
        run_frame(8'h81, 3'd7, 32'h4433_2211, -1, 0, 0, 1'b0);
        check_frame("blen7", 8'h81, 4, 32'h4433_2211, 45 + 5 * ACK);

`ifdef SERIAL_WRITER_ACK_EN
        run_frame(8'hC7, 3'd2, 32'h0000_5566, -1, 0, 0, 1'b1);
        check_eq("nack_latency", lat, 10);
        check_eq("nack_flag", nack_seen, 1);
        check_eq("nack_no_ready", nready, 0);
        check_eq("nack_done_count", ndone, 1);
        check_eq("nack_nbits", mbits.size(), 8);
`endif

        run_frame(8'hFF, 3'd2, 32'h0000_AAAA, -1, 0, 12 + ACK, 1'b0);

        run_frame(8'h7E, 3'd1, 32'h0000_00C3, -1, 0, 0, 1'b0);
        check_frame("recover", 8'h7E, 1, 32'h0000_00C3, 18 + 2 * ACK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
